// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: pipeline stall arbiter, flush sequencer and runaway-stall watchdog
//
// Ports:
//   Clk            rising-edge clock
//   Rst_n          synchronous active-low reset
//   stallreq_if    IF stage stall request (instruction fetch)
//   stallreq_id    ID stage stall request (load-use hazard)
//   stallreq_ex    EX stage stall request (multi-cycle mul/div)
//   stallreq_mem   MEM stage stall request (data memory wait)
//   flush_req      exception/redirect request, pulse or level
//   flush_pc       redirect target accompanying flush_req
//   stall[5:0]     hold enables: [0]=PC [1]=IF/ID [2]=ID/EX [3]=EX/MEM [4]=MEM/WB [5]=WB
//   flush          registered, clears all inter-stage registers to bubble
//   new_pc         redirect PC, valid while flush=1
//   stall_timeout  sticky flag, set after STALL_MAX consecutive stalled cycles
//   perf_stall_cnt count of cycles with stall[0]=1
//
// Build option: define CTRL_PERF_EN to instantiate the perf_stall_cnt counter;
// otherwise the port is tied to zero.
module pipe_stall_ctrl #(
   parameter int FLUSH_CYCLES = 1,
   parameter int STALL_MAX    = 255
) (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic        stallreq_if,
   input  logic        stallreq_id,
   input  logic        stallreq_ex,
   input  logic        stallreq_mem,
   input  logic        flush_req,
   input  logic [31:0] flush_pc,
   output logic [5:0]  stall,
   output logic        flush,
   output logic [31:0] new_pc,
   output logic        stall_timeout,
   output logic [31:0] perf_stall_cnt
);
   typedef enum logic {RUN, FLUSH} state_t;
   state_t      state_q, state_d;
   logic [3:0]  fcnt_q, fcnt_d;
   logic [31:0] new_pc_q, new_pc_d;
   logic        flush_q, flush_d;
   logic [15:0] tcnt_q, tcnt_d;
   logic        timeout_q, timeout_d;
   logic [5:0]  stall_req;
   always_comb begin
      // a stalled stage freezes itself and every stage upstream of it
      stall_req = stallreq_mem ? 6'b011111 :
                  stallreq_ex  ? 6'b001111 :
                  stallreq_id  ? 6'b000111 :
                  stallreq_if  ? 6'b000011 : 6'b000000;
      stall     = (!Rst_n || state_q == FLUSH || flush_req) ? 6'b000000 : stall_req;
      // a new request in either state restarts the flush window
      state_d   = flush_req ? FLUSH :
                  (state_q == FLUSH && fcnt_q == 4'd1) ? RUN : state_q;
      fcnt_d    = flush_req ? 4'(FLUSH_CYCLES) :
                  state_q == FLUSH ? fcnt_q - 4'd1 : fcnt_q;
      new_pc_d  = flush_req ? flush_pc : new_pc_q;
      flush_d   = state_d == FLUSH;
      tcnt_d    = (stall == 6'b000000 || flush_q) ? 16'h0000 :
                  tcnt_q == 16'hFFFF ? tcnt_q : tcnt_q + 16'd1;
      // the flag rises on the edge where the run length reaches STALL_MAX
      timeout_d = flush_req ? 1'b0 : timeout_q | (tcnt_d >= 16'(STALL_MAX));
   end
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state_q   <= RUN;
         fcnt_q    <= 4'd0;
         new_pc_q  <= 32'h0;
         flush_q   <= 1'b0;
         tcnt_q    <= 16'h0000;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         fcnt_q    <= fcnt_d;
         new_pc_q  <= new_pc_d;
         flush_q   <= flush_d;
         tcnt_q    <= tcnt_d;
         timeout_q <= timeout_d;
      end
   end
   assign flush         = flush_q;
   assign new_pc        = new_pc_q;
   assign stall_timeout = timeout_q;
`ifdef CTRL_PERF_EN
   logic [31:0] perf_q, perf_d;
   always_comb perf_d = perf_q + {31'b0, stall[0]};
   always_ff @(posedge Clk) begin
      if (!Rst_n) perf_q <= 32'h0;
      else        perf_q <= perf_d;
   end
   assign perf_stall_cnt = perf_q;
`else
   assign perf_stall_cnt = 32'h0;
`endif
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed and random checks of pipe_stall_ctrl against a cycle model
module tb_pipe_stall_ctrl;
   localparam int FC = 2;
   localparam int SM = 4;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        r_if = 1'b0, r_id = 1'b0, r_ex = 1'b0, r_mem = 1'b0;
   logic        freq = 1'b0;
   logic [31:0] fpc = 32'h0;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic        stall_timeout;
   logic [31:0] perf_stall_cnt;
   int          checks = 0;
   int          errors = 0;
   int          flush_left = 0;
   int          run_len = 0;
   logic        to_m = 1'b0;
   logic [31:0] pc_m = 32'h0;
   logic [31:0] perf_m = 32'h0;
   logic [5:0]  o_stall;
   logic        o_flush, o_to;
   logic [31:0] o_pc, o_perf;

   pipe_stall_ctrl #(.FLUSH_CYCLES(FC), .STALL_MAX(SM)) dut (
      .Clk(clk), .Rst_n(rst_n),
      .stallreq_if(r_if), .stallreq_id(r_id), .stallreq_ex(r_ex), .stallreq_mem(r_mem),
      .flush_req(freq), .flush_pc(fpc),
      .stall(stall), .flush(flush), .new_pc(new_pc),
      .stall_timeout(stall_timeout), .perf_stall_cnt(perf_stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // req = {mem, ex, id, if}; one clock cycle with the model compared mid-cycle
   task automatic step(input logic [3:0] req, input logic fr, input logic [31:0] pc, input logic rn);
      int lvl;
      logic [5:0] exp_stall;
      {r_mem, r_ex, r_id, r_if} = req;
      freq  = fr;
      fpc   = pc;
      rst_n = rn;
      lvl = 0;
      for (int k = 0; k < 4; k++) if (req[k]) lvl = k + 1;
      exp_stall = (lvl == 0 || !rn || fr || flush_left > 0) ? 6'd0 : 6'((1 << (lvl + 1)) - 1);
      @(negedge clk);
      o_stall = stall; o_flush = flush; o_pc = new_pc; o_to = stall_timeout; o_perf = perf_stall_cnt;
      chk("stall", 32'(o_stall), 32'(exp_stall));
      chk("flush", 32'(o_flush), 32'(flush_left > 0));
      chk("new_pc", o_pc, pc_m);
      chk("timeout", 32'(o_to), 32'(to_m));
`ifdef CTRL_PERF_EN
      chk("perf", o_perf, perf_m);
`else
      chk("perf", o_perf, 32'h0);
`endif
      @(posedge clk);
      if (!rn) begin
         flush_left = 0; run_len = 0; to_m = 1'b0; pc_m = 32'h0; perf_m = 32'h0;
      end else begin
         perf_m = perf_m + 32'(exp_stall[0]);
         run_len = exp_stall != 0 ? (run_len < 65535 ? run_len + 1 : 65535) : 0;
         if (fr) begin
            flush_left = FC; pc_m = pc; to_m = 1'b0;
         end else begin
            if (flush_left > 0) flush_left--;
            if (run_len >= SM) to_m = 1'b1;
         end
      end
      #1;
   endtask

   initial begin
      @(posedge clk); #1;
      step(4'b0000, 0, 0, 0);
      step(4'b0010, 0, 0, 0);
      // load-use stall for three cycles
      for (int i = 0; i < 3; i++) begin
         step(4'b0010, 0, 0, 1);
         chk("tp_id_stall", 32'(o_stall), 32'h07);
      end
      step(4'b0000, 0, 0, 1);
      chk("tp_id_release", 32'(o_stall), 32'h00);
      // priority between simultaneous requests
      step(4'b0101, 0, 0, 1);
      chk("tp_ex_wins", 32'(o_stall), 32'h0F);
      step(4'b1101, 0, 0, 1);
      chk("tp_mem_wins", 32'(o_stall), 32'h1F);
      // flush overrides a MEM stall in the request cycle
      step(4'b1000, 1, 32'h180, 1);
      chk("tp_flush_kills_stall", 32'(o_stall), 32'h00);
      for (int i = 0; i < 2; i++) begin
         step(4'b1000, 0, 0, 1);
         chk("tp_flush_on", 32'(o_flush), 32'h1);
         chk("tp_flush_pc", o_pc, 32'h180);
      end
      step(4'b1000, 0, 0, 1);
      chk("tp_flush_off", 32'(o_flush), 32'h0);
      chk("tp_mem_resume", 32'(o_stall), 32'h1F);
      // restart during the first flush cycle
      step(4'b0000, 1, 32'h180, 1);
      step(4'b0000, 1, 32'h200, 1);
      for (int i = 0; i < 2; i++) begin
         step(4'b0000, 0, 0, 1);
         chk("tp_restart_on", 32'(o_flush), 32'h1);
         chk("tp_restart_pc", o_pc, 32'h200);
      end
      step(4'b0000, 0, 0, 1);
      chk("tp_restart_off", 32'(o_flush), 32'h0);
      // runaway-stall watchdog
      for (int i = 1; i <= 6; i++) begin
         step(4'b0100, 0, 0, 1);
         if (i == 4) chk("tp_to_early", 32'(o_to), 32'h0);
         if (i == 5) chk("tp_to_set", 32'(o_to), 32'h1);
      end
      step(4'b0000, 0, 0, 1);
      chk("tp_to_sticky", 32'(o_to), 32'h1);
      step(4'b0000, 1, 32'h40, 1);
      step(4'b0000, 0, 0, 1);
      chk("tp_to_cleared", 32'(o_to), 32'h0);
      // perf counter across a flush and a mid-stall reset
      step(4'b0000, 0, 0, 0);
      for (int i = 0; i < 10; i++) step(4'b0100, 0, 0, 1);
      step(4'b0000, 1, 32'h80, 1);
      step(4'b0000, 0, 0, 1);
      step(4'b0000, 0, 0, 1);
      step(4'b0100, 0, 0, 0);
`ifdef CTRL_PERF_EN
      chk("tp_perf_before", o_perf, 32'd10);
`else
      chk("tp_perf_before", o_perf, 32'd0);
`endif
      step(4'b0100, 0, 0, 1);
      chk("tp_perf_after", o_perf, 32'd0);
      // random traffic
      for (int i = 0; i < 500; i++)
         step(4'($urandom), $urandom_range(0, 7) == 0, $urandom, $urandom_range(0, 63) != 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
